sram_2p_march_bist: RTL and testbench

SRAM_2P_MARCH_BIST -- requirements
Module: sram_2p_march_bist

---
 rtl/sram_2p_march_bist.sv | 154 +++++++++++++++
 tb/tb_sram_2p_march_bist.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sram_2p_march_bist.sv
// sram_2p_march_bist: March C- BIST controller driving the BIST pins of a two-port SRAM
module sram_2p_march_bist #(
  parameter int P_DATA_WIDTH = 20,
  parameter int P_ADDR_WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    fail,
  output logic [P_ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]              fail_elem,
  output logic                    bist_en,
  output logic [P_ADDR_WIDTH-1:0] a_bist_addr,
  output logic [P_DATA_WIDTH-1:0] a_bist_din,
  output logic [P_DATA_WIDTH-1:0] a_bist_bm,
  output logic                    a_bist_men,
  output logic                    a_bist_wen,
  output logic                    a_bist_ren,
  output logic [P_ADDR_WIDTH-1:0] b_bist_addr,
  output logic [P_DATA_WIDTH-1:0] b_bist_din,
  output logic [P_DATA_WIDTH-1:0] b_bist_bm,
  output logic                    b_bist_men,
  output logic                    b_bist_wen,
  output logic                    b_bist_ren,
  input  logic [P_DATA_WIDTH-1:0] a_dout,
  input  logic [P_DATA_WIDTH-1:0] b_dout
);
  localparam logic [P_ADDR_WIDTH-1:0] MAX = '1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t st_q, st_d;
  logic [2:0] elem_q, elem_d, celem_q, celem_d, fail_elem_q, fail_elem_d, nel;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d, caddr_q, caddr_d, fail_addr_q, fail_addr_d;
  logic ph_q, ph_d, a_men_q, a_men_d, a_wen_q, a_wen_d, a_ren_q, a_ren_d, b_ren_q, b_ren_d;
  logic din_q, din_d, cv_q, cv_d, cexp_q, cexp_d, fail_q, fail_d;
  logic go, two, down, end_el, last, wr, run_d, mis;
  logic [P_DATA_WIDTH-1:0] rd;
  // sequencing of march elements, next pin values, and first-mismatch capture
  always_comb begin
    go = start && (st_q == IDLE || st_q == DONE);
    two = elem_q >= 3'd1 && elem_q <= 3'd4;
    down = elem_q >= 3'd3 && elem_q <= 3'd5;
    end_el = down ? addr_q == '0 : addr_q == MAX;
    last = elem_q == 3'd6 && end_el;
    nel = elem_q + 3'd1;
    st_d = st_q;
    elem_d = elem_q;
    addr_d = addr_q;
    ph_d = ph_q;
    fail_d = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    rd = celem_q == 3'd6 ? b_dout : a_dout;
    mis = cv_q && rd != {P_DATA_WIDTH{cexp_q}};
    if (mis && !fail_q) begin
      fail_d = 1'b1;
      fail_addr_d = caddr_q;
      fail_elem_d = celem_q;
    end
    if (go) begin
      st_d = RUN;
      elem_d = '0;
      addr_d = '0;
      ph_d = 1'b0;
      fail_d = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = '0;
    end else if (st_q == RUN) begin
      if (last) begin
        st_d = DRAIN;
        elem_d = '0;
        addr_d = '0;
        ph_d = 1'b0;
      end else if (two && !ph_q) begin
        ph_d = 1'b1;
      end else begin
        ph_d = 1'b0;
        elem_d = end_el ? nel : elem_q;
        addr_d = end_el ? ((nel >= 3'd3 && nel <= 3'd5) ? MAX : '0)
                        : (down ? addr_q - 1'b1 : addr_q + 1'b1);
      end
    end else if (st_q == DRAIN) begin
      st_d = DONE;
    end
    run_d = st_d == RUN;
    wr = elem_d == 3'd0 || (elem_d >= 3'd1 && elem_d <= 3'd4 && ph_d);
    a_men_d = run_d && elem_d != 3'd6;
    a_wen_d = a_men_d && wr;
    a_ren_d = a_men_d && !wr;
    b_ren_d = run_d && elem_d == 3'd6;
    din_d = a_wen_d && (elem_d == 3'd1 || elem_d == 3'd3);
    cv_d = a_ren_q || b_ren_q;
    cexp_d = elem_q == 3'd2 || elem_q == 3'd4;
    celem_d = elem_q;
    caddr_d = addr_q;
  end
  // state, pin and compare-pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      elem_q <= '0;
      addr_q <= '0;
      ph_q <= 1'b0;
      a_men_q <= 1'b0;
      a_wen_q <= 1'b0;
      a_ren_q <= 1'b0;
      b_ren_q <= 1'b0;
      din_q <= 1'b0;
      cv_q <= 1'b0;
      cexp_q <= 1'b0;
      celem_q <= '0;
      caddr_q <= '0;
      fail_q <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      st_q <= st_d;
      elem_q <= elem_d;
      addr_q <= addr_d;
      ph_q <= ph_d;
      a_men_q <= a_men_d;
      a_wen_q <= a_wen_d;
      a_ren_q <= a_ren_d;
      b_ren_q <= b_ren_d;
      din_q <= din_d;
      cv_q <= cv_d;
      cexp_q <= cexp_d;
      celem_q <= celem_d;
      caddr_q <= caddr_d;
      fail_q <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end
  assign busy = st_q == RUN || st_q == DRAIN;
  assign bist_en = busy;
  assign done = st_q == DONE;
  assign fail = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign a_bist_addr = addr_q;
  assign a_bist_din = {P_DATA_WIDTH{din_q}};
  assign a_bist_bm = {P_DATA_WIDTH{a_men_q}};
  assign a_bist_men = a_men_q;
  assign a_bist_wen = a_wen_q;
  assign a_bist_ren = a_ren_q;
  assign b_bist_addr = addr_q;
  assign b_bist_din = '0;
  assign b_bist_bm = {P_DATA_WIDTH{b_ren_q}};
  assign b_bist_men = b_ren_q;
  assign b_bist_wen = 1'b0;
  assign b_bist_ren = b_ren_q;
endmodule

// File: tb/tb_sram_2p_march_bist.sv
// tb_sram_2p_march_bist: March C- BIST against a two-port SRAM model with injected faults
module tb_sram_2p_march_bist;
  localparam int AW = 4, DW = 20, N = 16, OPS = 11 * N;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic busy, done, fail, bist_en;
  logic [AW-1:0] fail_addr, a_bist_addr, b_bist_addr;
  logic [2:0] fail_elem;
  logic [DW-1:0] a_bist_din, a_bist_bm, b_bist_din, b_bist_bm, a_dout, b_dout;
  logic a_bist_men, a_bist_wen, a_bist_ren, b_bist_men, b_bist_wen, b_bist_ren;
  int checks = 0, failures = 0;
  int fkind = 0, faddr = 0, fbit = 0;
  logic [DW-1:0] mem [N];
  typedef struct {int port; bit wr; int addr; bit one; int elem;} op_t;
  op_t ops[$];

  sram_2p_march_bist #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .bist_en(bist_en),
    .a_bist_addr(a_bist_addr), .a_bist_din(a_bist_din), .a_bist_bm(a_bist_bm),
    .a_bist_men(a_bist_men), .a_bist_wen(a_bist_wen), .a_bist_ren(a_bist_ren),
    .b_bist_addr(b_bist_addr), .b_bist_din(b_bist_din), .b_bist_bm(b_bist_bm),
    .b_bist_men(b_bist_men), .b_bist_wen(b_bist_wen), .b_bist_ren(b_bist_ren),
    .a_dout(a_dout), .b_dout(b_dout));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] corrupt(input int port, input int addr, input logic [DW-1:0] v);
    logic [DW-1:0] m;
    m = DW'(1) << fbit;
    if (addr != faddr) return v;
    if (port == 0 && fkind == 1) return v | m;
    if (port == 0 && fkind == 2) return v ^ m;
    if (port == 1 && fkind == 3) return v ^ m;
    return v;
  endfunction

  always @(posedge clk) begin
    if (a_bist_men && a_bist_wen) mem[a_bist_addr] <= (mem[a_bist_addr] & ~a_bist_bm) | (a_bist_din & a_bist_bm);
    if (a_bist_men && a_bist_ren) a_dout <= corrupt(0, int'(a_bist_addr), mem[a_bist_addr]);
    if (b_bist_men && b_bist_ren) b_dout <= corrupt(1, int'(b_bist_addr), mem[b_bist_addr]);
  end

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  function automatic logic [127:0] all_out();
    return {busy, done, fail, fail_addr, fail_elem, bist_en,
            a_bist_addr, a_bist_din, a_bist_bm, a_bist_men, a_bist_wen, a_bist_ren,
            b_bist_addr, b_bist_din, b_bist_bm, b_bist_men, b_bist_wen, b_bist_ren};
  endfunction

  function automatic logic [127:0] obs_pins(input int port);
    return port == 1 ? {a_bist_men, a_bist_wen, a_bist_ren, b_bist_men, b_bist_wen, b_bist_ren, b_bist_addr, b_bist_din, b_bist_bm}
                     : {a_bist_men, a_bist_wen, a_bist_ren, b_bist_men, b_bist_wen, b_bist_ren, a_bist_addr, a_bist_din, a_bist_bm};
  endfunction

  function automatic logic [127:0] exp_pins(input op_t op);
    logic [2:0] fl;
    logic [DW-1:0] d;
    fl = op.wr ? 3'b110 : 3'b101;
    d = (op.wr && op.one) ? '1 : '0;
    return op.port == 1 ? {3'b000, fl, AW'(op.addr), d, {DW{1'b1}}}
                        : {fl, 3'b000, AW'(op.addr), d, {DW{1'b1}}};
  endfunction

  // March C- written out as element list: direction, then (is_write, value) per op
  task automatic build_ops();
    ops.delete();
    for (int e = 0; e < 7; e++)
      for (int i = 0; i < N; i++) begin
        int a;
        a = (e >= 3 && e <= 5) ? N - 1 - i : i;
        case (e)
          0: ops.push_back('{0, 1, a, 0, e});
          1: begin ops.push_back('{0, 0, a, 0, e}); ops.push_back('{0, 1, a, 1, e}); end
          2: begin ops.push_back('{0, 0, a, 1, e}); ops.push_back('{0, 1, a, 0, e}); end
          3: begin ops.push_back('{0, 0, a, 0, e}); ops.push_back('{0, 1, a, 1, e}); end
          4: begin ops.push_back('{0, 0, a, 1, e}); ops.push_back('{0, 1, a, 0, e}); end
          5: ops.push_back('{0, 0, a, 0, e});
          default: ops.push_back('{1, 0, a, 0, e});
        endcase
      end
  endtask

  task automatic do_run(input int fk, input int fa, input int fb, input int rep);
    bit img [N];
    bit ef;
    int efa, efe;
    logic [DW-1:0] ev;
    fkind = fk; faddr = fa; fbit = fb;
    ef = 0; efa = 0; efe = 0;
    foreach (ops[k]) begin
      ev = ops[k].one ? '1 : '0;
      if (ops[k].wr) img[ops[k].addr] = ops[k].one;
      else if (!ef && corrupt(ops[k].port, ops[k].addr, img[ops[k].addr] ? '1 : '0) != ev) begin
        ef = 1; efa = ops[k].addr; efe = ops[k].elem;
      end
    end
    start = 1'b1;
    for (int cyc = 1; cyc <= OPS + 2; cyc++) begin
      @(posedge clk);
      #1;
      start = (cyc == rep);
      chk("busy", {busy, bist_en}, {2{cyc <= OPS + 1}});
      chk("done", done, cyc == OPS + 2);
      if (cyc == 1) chk("cleared", {fail, fail_addr, fail_elem}, 0);
      if (cyc <= OPS) chk($sformatf("op%0d", cyc), obs_pins(ops[cyc-1].port), exp_pins(ops[cyc-1]));
      else chk("idle_pins", {a_bist_men, a_bist_wen, a_bist_ren, b_bist_men, b_bist_wen, b_bist_ren}, 0);
      if (cyc == 5 * N + 1) chk("e3_first", {a_bist_addr, a_bist_ren}, {4'd15, 1'b1});
      if (cyc == 5 * N + 2) chk("e3_second", {a_bist_addr, a_bist_wen, a_bist_din}, {4'd15, 1'b1, {DW{1'b1}}});
      if (cyc == 5 * N + 3) chk("e3_third", {a_bist_addr, a_bist_ren}, {4'd14, 1'b1});
    end
    chk("fail", {fail, fail_addr, fail_elem}, {ef, AW'(efa), 3'(efe)});
  endtask

  initial begin
    build_ops();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", all_out(), 0);
    reset = 1'b0;
    do_run(0, 0, 0, 0);
    do_run(1, 5, 0, 0);
    chk("stuck_a5", {fail, fail_addr, fail_elem}, {1'b1, 4'd5, 3'd1});
    do_run(3, 9, 3, 0);
    chk("port_b9", {fail, fail_addr, fail_elem}, {1'b1, 4'd9, 3'd6});
    do_run(0, 0, 0, 40);
    start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("midrun_reset", all_out(), 0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("start_with_reset_ignored", {busy, done}, 0);
    do_run(0, 0, 0, 0);
    for (int r = 0; r < 4; r++)
      do_run(int'($urandom_range(1, 3)), int'($urandom_range(0, N - 1)), int'($urandom_range(0, DW - 1)), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
